snake_board_scanner: RTL

SNAKE_BOARD_SCANNER -- requirements
Module: snake_board_scanner

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_scan_ctr.sv | 63 ++++++
 rtl/snake_board_scanner.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pkg
//  Purpose  : Shared geometry, state encoding and helpers for the 8x8 board
//             row scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int BOARD_W     = 64;
  localparam int ROW_W       = 3;
  localparam int DWELL_W     = 8;
  localparam int FRAME_CNT_W = 16;

  // Scanner state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  // One-hot row drive pattern for a row index
  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
    return ROWS'(1) << row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_scan_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : snake_scan_ctr
//  Purpose  : Dwell/row counter pair for the board scanner. Reports the
//             current last-dwell / last-row strobes and a one-cycle lookahead
//             (row and strobes of the next cycle) so the top can register
//             its outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_scan_ctr
  import snake_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [ROW_W-1:0] row_nxt_o,
  output logic             last_dwell_o,
  output logic             last_row_o,
  output logic             last_dwell_nxt_o,
  output logic             last_row_nxt_o
);

  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ROW_W-1:0]   row_q, row_d;

  // Advance dwell each enabled cycle; roll into the next row after the last dwell
  always_comb begin
    dwell_d = dwell_q;
    row_d   = row_q;
    if (en_i) begin
      if (dwell_q == LAST_DWELL) begin
        dwell_d = '0;
        row_d   = row_q + 3'd1;   // 7 wraps naturally to 0
      end else begin
        dwell_d = dwell_q + 8'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      row_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
    end
  end

  assign row_nxt_o        = row_d;
  assign last_dwell_o     = (dwell_q == LAST_DWELL);
  assign last_row_o       = (row_q == LAST_ROW);
  assign last_dwell_nxt_o = (dwell_d == LAST_DWELL);
  assign last_row_nxt_o   = (row_d == LAST_ROW);

endmodule
`default_nettype wire

// File: rtl/snake_board_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : snake_board_scanner
//  Purpose  : Scans an 8x8 board bitmap onto one-hot row drives and column
//             data. New boards are double-buffered and only swapped in at the
//             end of row 7 so a frame is never torn.
//  Config   : define SNAKE_BLANK_EN to insert a one-cycle blank after every row.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_board_scanner
  import snake_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [BOARD_W-1:0]     snake_in,
  input  logic                   snake_valid,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        col_data,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy
);

  logic [1:0]             state_q, state_d;
  logic [BOARD_W-1:0]     display_q, display_d;
  logic [BOARD_W-1:0]     pending_q, pending_d;
  logic                   pflag_q, pflag_d;
  logic [FRAME_CNT_W-1:0] fcount_q, fcount_d;
  logic [ROWS-1:0]        row_sel_q, row_sel_d;
  logic [COLS-1:0]        col_q, col_d;
  logic                   fdone_q, fdone_d;
  logic                   busy_q, busy_d;

  logic [ROW_W-1:0] w_row_nxt;
  logic             w_last_dwell, w_last_row;
  logic             w_last_dwell_nxt, w_last_row_nxt;
  logic             w_end_row, w_swap;

  snake_scan_ctr #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_ctr (
    .clk_i            (clock),
    .rst_i            (reset),
    .en_i             (state_q == ST_SCAN),
    .row_nxt_o        (w_row_nxt),
    .last_dwell_o     (w_last_dwell),
    .last_row_o       (w_last_row),
    .last_dwell_nxt_o (w_last_dwell_nxt),
    .last_row_nxt_o   (w_last_row_nxt)
  );

  // Last driven cycle of a row, and of row 7 (the frame boundary / swap point)
  assign w_end_row = (state_q == ST_SCAN) && w_last_dwell;
  assign w_swap    = w_end_row && w_last_row;

  // FSM, buffer swap and frame counter next-state logic
  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    pending_d = pending_q;
    pflag_d   = pflag_q;
    fcount_d  = fcount_q;
    case (state_q)
      ST_IDLE: begin
        if (snake_valid) begin
          state_d   = ST_SCAN;
          display_d = snake_in;
        end
      end
      ST_SCAN: begin
`ifdef SNAKE_BLANK_EN
        if (w_end_row) state_d = ST_BLANK;
`endif
      end
`ifdef SNAKE_BLANK_EN
      ST_BLANK: state_d = ST_SCAN;
`endif
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) begin
      // Swap first so a coincident strobe lands in pending for the next frame
      if (w_swap && pflag_q) begin
        display_d = pending_q;
        pflag_d   = 1'b0;
      end
      if (snake_valid) begin
        pending_d = snake_in;
        pflag_d   = 1'b1;
      end
    end
    if (w_swap) fcount_d = fcount_q + 16'd1;
  end

  // Output decode from next-cycle state so every output comes straight off a flop
  always_comb begin
    row_sel_d = '0;
    col_d     = '0;
    fdone_d   = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    if (state_d == ST_SCAN) begin
      row_sel_d = row_onehot(w_row_nxt);
      col_d     = display_d[{w_row_nxt, 3'b000} +: COLS];
      fdone_d   = w_last_dwell_nxt && w_last_row_nxt;
    end
  end

  // State, buffers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      display_q <= '0;
      pending_q <= '0;
      pflag_q   <= 1'b0;
      fcount_q  <= '0;
      row_sel_q <= '0;
      col_q     <= '0;
      fdone_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      pending_q <= pending_d;
      pflag_q   <= pflag_d;
      fcount_q  <= fcount_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fdone_q   <= fdone_d;
      busy_q    <= busy_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_q;
  assign frame_done  = fdone_q;
  assign frame_count = fcount_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
